systolic_array_top: RTL and testbench

//  Output-stationary ARRAY_SIZE x ARRAY_SIZE systolic matrix-multiply engine (GPT-2 accelerator MAC core).
//  On a start pulse, captures A (activations) and B (weights) and computes C = A x B with skewed

---
 rtl/systolic_array_pkg.sv | 22 ++
 rtl/systolic_pe.sv | 49 ++++
 rtl/systolic_array_top.sv | 185 ++++++++++++++++++
 tb/tb_systolic_array_top.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_pkg.sv
// Shared definitions for the output-stationary systolic matrix-multiply engine:
// default geometry and widths, the controller state encoding and the step count.
package systolic_array_pkg;

  localparam int DEF_ARRAY_SIZE   = 8;
  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_WEIGHT_WIDTH = 8;
  localparam int DEF_ACCUM_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Number of compute steps needed for the last skewed operand pair
  // (row N-1, column N-1, k = N-1) to reach the bottom-right PE.
  function automatic int total_steps(input int n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Single processing element: forwards activation right and weight down through
// one register each, and accumulates the signed product into a wrapping accumulator.
module systolic_pe
  import systolic_array_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           enable,
  input  logic signed [DATA_WIDTH-1:0]   a_in,
  input  logic signed [WEIGHT_WIDTH-1:0] b_in,
  output logic signed [DATA_WIDTH-1:0]   a_out,
  output logic signed [WEIGHT_WIDTH-1:0] b_out,
  output logic signed [ACCUM_WIDTH-1:0]  acc
);

  logic signed [ACCUM_WIDTH-1:0] a_ext_s;
  logic signed [ACCUM_WIDTH-1:0] b_ext_s;
  logic signed [ACCUM_WIDTH-1:0] prod_s;

  // Sign-extend both operands to the accumulator width; the product wraps there.
  always_comb begin
    a_ext_s = ACCUM_WIDTH'(a_in);
    b_ext_s = ACCUM_WIDTH'(b_in);
    prod_s  = a_ext_s * b_ext_s;
  end

  // Operand forwarding and multiply-accumulate; clear wins over a compute step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clear) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (enable) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + prod_s;
    end
  end

endmodule

// File: rtl/systolic_array_top.sv
// Output-stationary N x N systolic matrix multiplier: captures A and B on start,
// streams skewed rows of A from the left and columns of B from the top, then
// latches every accumulator onto result_flat with a one-cycle done pulse.
module systolic_array_top
  import systolic_array_pkg::*;
#(
  parameter int ARRAY_SIZE   = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]   matrix_a_flat,
  input  logic [WEIGHT_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] matrix_b_flat,
  output logic [ACCUM_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]  result_flat,
  output logic                                       computation_done,
  output logic                                       result_valid
);

  localparam int N         = ARRAY_SIZE;
  localparam int STEPS     = total_steps(N);
  localparam int LAST_STEP = STEPS - 1;
  localparam int STEP_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1;

  state_e                          state_r;
  logic [STEP_W-1:0]               step_r;
  logic signed [DATA_WIDTH-1:0]    a_cap_r [N][N];
  logic signed [WEIGHT_WIDTH-1:0]  b_cap_r [N][N];
  logic                            done_r;
  logic                            valid_r;
  logic [ACCUM_WIDTH*N*N-1:0]      result_r;

  logic                            pe_clear_s;
  logic                            pe_enable_s;

  // a_bus_s[r][c] feeds PE(r,c); column N is the unused right-hand spill.
  // b_bus_s[r][c] feeds PE(r,c); row N is the unused bottom spill.
  logic signed [DATA_WIDTH-1:0]    a_bus_s [N][N+1];
  logic signed [WEIGHT_WIDTH-1:0]  b_bus_s [N+1][N];
  logic signed [ACCUM_WIDTH-1:0]   acc_s   [N][N];

  assign result_flat      = result_r;
  assign computation_done = done_r;
  assign result_valid     = valid_r;

  // PE control: clear all accumulators on an accepted start, step only while computing.
  always_comb begin
    pe_clear_s  = 1'b0;
    pe_enable_s = 1'b0;
    case (state_r)
      IDLE: begin
        pe_clear_s  = start;
        pe_enable_s = 1'b0;
      end
      COMPUTE: begin
        pe_clear_s  = 1'b0;
        pe_enable_s = 1'b1;
      end
      DONE: begin
        pe_clear_s  = 1'b0;
        pe_enable_s = 1'b0;
      end
      default: begin
        pe_clear_s  = 1'b0;
        pe_enable_s = 1'b0;
      end
    endcase
  end

  // Left-edge skew: row r sees A[r][k] at step k+r, zero outside that window.
  for (genvar r = 0; r < N; r++) begin : g_row_feed
    logic [STEP_W-1:0]            k_s;
    logic signed [DATA_WIDTH-1:0] feed_s;

    // Select the activation for this row at the current step.
    always_comb begin
      k_s = step_r - STEP_W'(r);
      if ((state_r == COMPUTE) && (step_r >= STEP_W'(r)) && (step_r < STEP_W'(r + N))) begin
        feed_s = a_cap_r[r][k_s[IDX_W-1:0]];
      end else begin
        feed_s = '0;
      end
    end

    assign a_bus_s[r][0] = feed_s;
  end

  // Top-edge skew: column c sees B[k][c] at step k+c, zero outside that window.
  for (genvar c = 0; c < N; c++) begin : g_col_feed
    logic [STEP_W-1:0]              k_s;
    logic signed [WEIGHT_WIDTH-1:0] feed_s;

    // Select the weight for this column at the current step.
    always_comb begin
      k_s = step_r - STEP_W'(c);
      if ((state_r == COMPUTE) && (step_r >= STEP_W'(c)) && (step_r < STEP_W'(c + N))) begin
        feed_s = b_cap_r[k_s[IDX_W-1:0]][c];
      end else begin
        feed_s = '0;
      end
    end

    assign b_bus_s[0][c] = feed_s;
  end

  // N x N grid of processing elements.
  for (genvar r = 0; r < N; r++) begin : g_pe_row
    for (genvar c = 0; c < N; c++) begin : g_pe_col
      systolic_pe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .ACCUM_WIDTH  (ACCUM_WIDTH)
      ) u_pe (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (pe_clear_s),
        .enable (pe_enable_s),
        .a_in   (a_bus_s[r][c]),
        .b_in   (b_bus_s[r][c]),
        .a_out  (a_bus_s[r][c+1]),
        .b_out  (b_bus_s[r+1][c]),
        .acc    (acc_s[r][c])
      );
    end
  end

  // Controller: input capture, step counting, result latch and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      step_r   <= '0;
      done_r   <= 1'b0;
      valid_r  <= 1'b0;
      result_r <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_cap_r[r][c] <= '0;
          b_cap_r[r][c] <= '0;
        end
      end
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                a_cap_r[r][c] <= matrix_a_flat[(r*N+c)*DATA_WIDTH +: DATA_WIDTH];
                b_cap_r[r][c] <= matrix_b_flat[(r*N+c)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
              end
            end
            step_r  <= '0;
            valid_r <= 1'b0;
            state_r <= COMPUTE;
          end
        end
        COMPUTE: begin
          done_r <= 1'b0;
          step_r <= step_r + STEP_W'(1);
          if (step_r == STEP_W'(LAST_STEP)) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              result_r[(r*N+c)*ACCUM_WIDTH +: ACCUM_WIDTH] <= acc_s[r][c];
            end
          end
          done_r  <= 1'b1;
          valid_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_top.sv
// Bench for systolic_array_top: a matrix-level reference model predicts the
// done/valid timing and the product; one process compares every cycle, and
// directed tests pin selected elements to hand-computed values.
module tb_systolic_array_top;

  localparam int N   = 8;
  localparam int DW  = 16;
  localparam int WW  = 8;
  localparam int AW  = 32;
  localparam int LAT = 3 * N - 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [DW*N*N-1:0] matrix_a_flat;
  logic [WW*N*N-1:0] matrix_b_flat;
  logic [AW*N*N-1:0] result_flat;
  logic              computation_done;
  logic              result_valid;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int ma [N][N];
  int mb [N][N];

  systolic_array_top dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .matrix_a_flat    (matrix_a_flat),
    .matrix_b_flat    (matrix_b_flat),
    .result_flat      (result_flat),
    .computation_done (computation_done),
    .result_valid     (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain matrix product with sign extension, wrapping in 32-bit int.
  function automatic logic [AW*N*N-1:0] model_product(input logic [DW*N*N-1:0] fa,
                                                      input logic [WW*N*N-1:0] fb);
    logic [AW*N*N-1:0] res;
    logic signed [DW-1:0] ta;
    logic signed [WW-1:0] tb;
    int s;
    res = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) begin
          ta = fa[(i*N+k)*DW +: DW];
          tb = fb[(k*N+j)*WW +: WW];
          s  = s + int'(ta) * int'(tb);
        end
        res[(i*N+j)*AW +: AW] = s;
      end
    end
    return res;
  endfunction

  // Reference model state
  int                cyc = 0;
  int                m_fin = 0;
  bit                m_busy = 1'b0;
  bit                m_done = 1'b0;
  bit                m_valid = 1'b0;
  logic [AW*N*N-1:0] m_pending = '0;
  logic [AW*N*N-1:0] m_result = '0;

  // Model: a start is taken only when no run is in flight; result appears LAT edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_valid  <= 1'b0;
      m_result <= '0;
    end else begin
      cyc    <= cyc + 1;
      m_done <= 1'b0;
      if (m_busy) begin
        if (cyc == m_fin) begin
          m_busy   <= 1'b0;
          m_done   <= 1'b1;
          m_valid  <= 1'b1;
          m_result <= m_pending;
        end
      end else if (start) begin
        m_busy    <= 1'b1;
        m_fin     <= cyc + LAT;
        m_valid   <= 1'b0;
        m_pending <= model_product(matrix_a_flat, matrix_b_flat);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("done_pulse", {63'd0, computation_done}, {63'd0, m_done});
      check("valid_level", {63'd0, result_valid}, {63'd0, m_valid});
      n_cmp++;
      if (result_flat !== m_result) begin
        n_bad++;
        for (int e = 0; e < N * N; e++) begin
          if (result_flat[e*AW +: AW] !== m_result[e*AW +: AW]) begin
            $display("FAIL result C[%0d][%0d] @cyc %0d: got %0d expected %0d", e / N, e % N, cyc,
                     $signed(result_flat[e*AW +: AW]), $signed(m_result[e*AW +: AW]));
            break;
          end
        end
      end
    end
  end

  function automatic logic [63:0] get_c(input int i, input int j);
    logic signed [AW-1:0] v;
    v = result_flat[(i*N+j)*AW +: AW];
    return 64'(v);
  endfunction

  task automatic clear_mats();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
    end
  endtask

  task automatic load();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        matrix_a_flat[(i*N+j)*DW +: DW] = DW'(ma[i][j]);
        matrix_b_flat[(i*N+j)*WW +: WW] = WW'(mb[i][j]);
      end
    end
  endtask

  // Start a run (start held for 'hold' cycles, optional extra pulse) and return
  // the number of edges between the accepting edge and the done edge.
  task automatic run(input int hold, input int pulse_at, output int lat);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    repeat (hold) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    for (int w = 0; w < 60 && !seen; w++) begin
      @(negedge clk);
      lat++;
      start = (lat - 1 == pulse_at);
      if (computation_done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
    lat = lat - 1;
  endtask

  int lat;
  int n_done;

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    matrix_a_flat = '0;
    matrix_b_flat = '0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_c00", get_c(0, 0), 64'd0);
    check("rst_valid", {63'd0, result_valid}, 64'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // diag(1,2,3,4) x B(4x6)
    clear_mats();
    for (int i = 0; i < 4; i++) ma[i][i] = i + 1;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 6; c++) mb[r][c] = (r + 1) * 10 + c + 1;
    load();
    run(1, -1, lat);
    check("t1_latency", 64'(lat), 64'd23);
    check("t1_c00", get_c(0, 0), 64'd11);
    check("t1_c12", get_c(1, 2), 64'd46);
    check("t1_c35", get_c(3, 5), 64'd184);
    check("t1_c36", get_c(3, 6), 64'd0);

    // 2*I(6x6) x B(6x3)
    clear_mats();
    for (int i = 0; i < 6; i++) ma[i][i] = 2;
    for (int r = 0; r < 6; r++) for (int c = 0; c < 3; c++) mb[r][c] = 3 * r + c + 1;
    load();
    run(1, -1, lat);
    check("t2_c00", get_c(0, 0), 64'd2);
    check("t2_c52", get_c(5, 2), 64'd36);
    check("t2_c06", get_c(0, 6), 64'd0);
    check("t2_c60", get_c(6, 0), 64'd0);

    // I(3x3) x B(3x8)
    clear_mats();
    for (int i = 0; i < 3; i++) ma[i][i] = 1;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 8; c++) mb[r][c] = 8 * r + c + 1;
    load();
    run(1, -1, lat);
    check("t3_c07", get_c(0, 7), 64'd8);
    check("t3_c27", get_c(2, 7), 64'd24);
    check("t3_c30", get_c(3, 0), 64'd0);

    // all ones, start held 3 cycles
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin ma[i][j] = 1; mb[i][j] = 1; end
    load();
    run(3, -1, lat);
    check("t4_latency", 64'(lat), 64'd23);
    check("t4_c00", get_c(0, 0), 64'd8);
    check("t4_c77", get_c(7, 7), 64'd8);
    repeat (5) @(negedge clk);
    check("t4_valid_hold", {63'd0, result_valid}, 64'd1);
    check("t4_done_low", {63'd0, computation_done}, 64'd0);

    // signed: -3 x -2, second start pulse mid-compute
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin ma[i][j] = -3; mb[i][j] = -2; end
    load();
    run(1, 5, lat);
    check("t5_latency", 64'(lat), 64'd23);
    check("t5_c44", get_c(4, 4), 64'd48);
    repeat (3) @(negedge clk);

    // start held long enough to be taken twice back to back
    clear_mats();
    for (int i = 0; i < 6; i++) ma[i][i] = 2;
    for (int r = 0; r < 6; r++) for (int c = 0; c < 3; c++) mb[r][c] = 3 * r + c + 1;
    load();
    n_done = 0;
    @(negedge clk);
    start = 1'b1;
    for (int w = 0; w < 60; w++) begin
      @(negedge clk);
      if (w == 29) start = 1'b0;
      if (computation_done) n_done++;
    end
    check("t6_done_count", 64'(n_done), 64'd2);
    check("t6_c52", get_c(5, 2), 64'd36);

    // reset in the middle of a run
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin ma[i][j] = 1; mb[i][j] = 1; end
    load();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_c52", get_c(5, 2), 64'd0);
    check("rst_mid_valid", {63'd0, result_valid}, 64'd0);
    check("rst_mid_done", {63'd0, computation_done}, 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    clear_mats();
    for (int i = 0; i < 4; i++) ma[i][i] = i + 1;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 6; c++) mb[r][c] = (r + 1) * 10 + c + 1;
    load();
    run(1, -1, lat);
    check("t7_latency", 64'(lat), 64'd23);
    check("t7_c00", get_c(0, 0), 64'd11);
    check("t7_c35", get_c(3, 5), 64'd184);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
